// File: rtl/bmp_pkg.sv
// Shared encodings and BMP header layout for the framebuffer loader.
package bmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FILE, S_HEADER, S_SKIP, S_PIXEL, S_PAD, S_DONE, S_ERR
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SIG     = 3'd1;
  localparam logic [2:0] ERR_SIZE    = 3'd2;
  localparam logic [2:0] ERR_BPP     = 3'd3;
  localparam logic [2:0] ERR_COMP    = 3'd4;
  localparam logic [2:0] ERR_OFFSET  = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;

  localparam logic [3:0] ST_IDLE    = 4'h0;
  localparam logic [3:0] ST_SD_OK   = 4'h1;
  localparam logic [3:0] ST_HEADER  = 4'h2;
  localparam logic [3:0] ST_LOADING = 4'h3;
  localparam logic [3:0] ST_DISPLAY = 4'h4;
  localparam logic [3:0] ST_ERROR   = 4'hE;

  localparam int unsigned OFS_OFFSET = 10;
  localparam int unsigned OFS_WIDTH  = 18;
  localparam int unsigned OFS_HEIGHT = 22;
  localparam int unsigned OFS_BPP    = 28;
  localparam int unsigned OFS_COMP   = 30;
  localparam int unsigned HDR_LEN    = 54;

  localparam logic [7:0] SIG0 = 8'h42;
  localparam logic [7:0] SIG1 = 8'h4D;

endpackage

// File: rtl/bmp_load_ctrl_hdr_parse.sv
// bmp_hdr_parse: captures the 54-byte BMP header and reports the first failing check.
module bmp_hdr_parse
  import bmp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        cap,
  input  logic [31:0] byte_idx,
  input  logic [7:0]  data,
  output logic [31:0] offset,
  output logic        top_down,
  output logic [1:0]  pad,
  output logic        valid,
  output logic [2:0]  err_code
);

  logic [7:0]  sig0, sig1;
  logic [31:0] width, height, comp, abs_h;
  logic [15:0] bpp;
  logic [31:0] rel_ofs, rel_w, rel_h, rel_bpp, rel_comp;

  // Unsigned wrap makes bytes before a field look out of range.
  assign rel_ofs  = byte_idx - 32'(OFS_OFFSET);
  assign rel_w    = byte_idx - 32'(OFS_WIDTH);
  assign rel_h    = byte_idx - 32'(OFS_HEIGHT);
  assign rel_bpp  = byte_idx - 32'(OFS_BPP);
  assign rel_comp = byte_idx - 32'(OFS_COMP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig0 <= '0; sig1 <= '0; offset <= '0; width <= '0;
      height <= '0; bpp <= '0; comp <= '0;
    end else if (clr) begin
      sig0 <= '0; sig1 <= '0; offset <= '0; width <= '0;
      height <= '0; bpp <= '0; comp <= '0;
    end else if (cap) begin
      if (byte_idx == 32'd0) sig0 <= data;
      if (byte_idx == 32'd1) sig1 <= data;
      if (rel_ofs  < 32'd4) offset[{rel_ofs[1:0], 3'b000} +: 8] <= data;
      if (rel_w    < 32'd4) width[{rel_w[1:0], 3'b000} +: 8]    <= data;
      if (rel_h    < 32'd4) height[{rel_h[1:0], 3'b000} +: 8]   <= data;
      if (rel_bpp  < 32'd2) bpp[{rel_bpp[0], 3'b000} +: 8]      <= data;
      if (rel_comp < 32'd4) comp[{rel_comp[1:0], 3'b000} +: 8]  <= data;
    end
  end

  assign abs_h    = height[31] ? (~height + 32'd1) : height;
  assign top_down = height[31];
  assign pad      = width[1:0];
  assign valid    = (err_code == ERR_NONE);

  always_comb begin
    err_code = ERR_NONE;
    if (sig0 != SIG0 || sig1 != SIG1)
      err_code = ERR_SIG;
    else if (width != 32'(H_ACTIVE) || abs_h != 32'(V_ACTIVE))
      err_code = ERR_SIZE;
    else if (bpp != 16'd24)
      err_code = ERR_BPP;
    else if (comp != 32'd0)
      err_code = ERR_COMP;
    else if (offset < 32'(HDR_LEN))
      err_code = ERR_OFFSET;
  end

endmodule

// File: rtl/bmp_load_ctrl.sv
// bmp_load_ctrl: streams a 24-bit BMP from the SD reader into the framebuffer,
// validating the header and mapping rows to linear write addresses.
//
// state     | meaning
// IDLE      | waiting for start; status shows card readiness
// WAIT_FILE | armed, waiting for the reader to open the file
// HEADER    | capturing and validating bytes 0..53
// SKIP      | dropping bytes up to the pixel-data offset
// PIXEL     | assembling B,G,R triples into framebuffer writes
// PAD       | dropping row padding bytes
// DONE      | frame complete, held
// ERR       | load aborted, err_code held
module bmp_load_ctrl
  import bmp_pkg::*;
#(
  parameter int          H_ACTIVE       = 640,
  parameter int          V_ACTIVE       = 480,
  parameter int          ADDR_WIDTH     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  card_ok,
  input  logic                  file_found,
  input  logic                  outen,
  input  logic [7:0]            outbyte,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [23:0]           fb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [3:0]            status
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] H_STEP   = ADDR_WIDTH'(H_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] BASE_BU  = ADDR_WIDTH'((V_ACTIVE - 1) * H_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(H_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(V_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);

  state_t state, state_nx;

  logic [31:0]           byte_idx;
  logic [1:0]            phase, pad_cnt;
  logic [ADDR_WIDTH-1:0] col, row_cnt, row_base;
  logic [TW-1:0]         tmo_cnt;
  logic [7:0]            pix_b, pix_g;
  logic [3:0]            status_nx;

  logic [31:0] hdr_offset;
  logic        hdr_top_down, hdr_valid;
  logic [1:0]  hdr_pad;
  logic [2:0]  hdr_err;

  logic in_load, take, restart, hdr_last, row_end, frame_end, tmo_hit, load_fault;

  assign in_load    = (state == S_HEADER) || (state == S_SKIP) ||
                      (state == S_PIXEL)  || (state == S_PAD);
  assign take       = in_load && outen && file_found;
  assign restart    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign hdr_last   = (state == S_HEADER) && take && (byte_idx == 32'(HDR_LEN - 1));
  assign row_end    = (state == S_PIXEL) && take && (phase == 2'd2) && (col == COL_LAST);
  assign frame_end  = row_end && (row_cnt == ROW_LAST);
  assign tmo_hit    = in_load && !take && (tmo_cnt == TW'(1));
  assign load_fault = in_load && (!file_found || tmo_hit);

  bmp_hdr_parse #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_hdr (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (restart),
    .cap      ((state == S_HEADER) && take),
    .byte_idx (byte_idx),
    .data     (outbyte),
    .offset   (hdr_offset),
    .top_down (hdr_top_down),
    .pad      (hdr_pad),
    .valid    (hdr_valid),
    .err_code (hdr_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      status <= ST_IDLE;
    end else begin
      state  <= state_nx;
      status <= status_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_WAIT_FILE;
      S_WAIT_FILE: if (file_found) state_nx = S_HEADER;
      S_HEADER:
        if (hdr_last) begin
          if (!hdr_valid)                     state_nx = S_ERR;
          else if (hdr_offset == 32'(HDR_LEN)) state_nx = S_PIXEL;
          else                                state_nx = S_SKIP;
        end
      S_SKIP:      if (take && byte_idx == hdr_offset - 32'd1) state_nx = S_PIXEL;
      S_PIXEL:
        if (frame_end)                      state_nx = S_DONE;
        else if (row_end && hdr_pad != 2'd0) state_nx = S_PAD;
      S_PAD:       if (take && pad_cnt == 2'd1) state_nx = S_PIXEL;
      default:     if (start) state_nx = S_WAIT_FILE;
    endcase
    if (load_fault) state_nx = S_ERR;
  end

  always_comb begin
    busy  = (state == S_WAIT_FILE) || in_load;
    done  = (state == S_DONE);
    error = (state == S_ERR);
    case (state_nx)
      S_IDLE:                   status_nx = card_ok ? ST_SD_OK : ST_IDLE;
      S_WAIT_FILE, S_HEADER:    status_nx = ST_HEADER;
      S_SKIP, S_PIXEL, S_PAD:   status_nx = ST_LOADING;
      S_DONE:                   status_nx = ST_DISPLAY;
      default:                  status_nx = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_idx <= '0; phase <= '0; pad_cnt <= '0; col <= '0; row_cnt <= '0;
      row_base <= '0; tmo_cnt <= '0; pix_b <= '0; pix_g <= '0;
      fb_we <= 1'b0; fb_addr <= '0; fb_data <= '0; err_code <= ERR_NONE;
    end else begin
      fb_we <= 1'b0;
      if (restart) begin
        byte_idx <= '0; phase <= '0; pad_cnt <= '0; col <= '0; row_cnt <= '0;
        row_base <= '0; tmo_cnt <= '0; err_code <= ERR_NONE;
      end else begin
        if ((state == S_WAIT_FILE && file_found) || take)
          tmo_cnt <= TW'(TIMEOUT_CYCLES);
        else if (in_load && tmo_cnt != '0)
          tmo_cnt <= tmo_cnt - TW'(1);
        if (take) byte_idx <= byte_idx + 32'd1;
        if (hdr_last) row_base <= hdr_top_down ? '0 : BASE_BU;
        if (state == S_PIXEL && take) begin
          case (phase)
            2'd0: begin pix_b <= outbyte; phase <= 2'd1; end
            2'd1: begin pix_g <= outbyte; phase <= 2'd2; end
            default: begin
              fb_we   <= 1'b1;
              fb_data <= {outbyte, pix_g, pix_b};
              fb_addr <= row_base + col;
              phase   <= 2'd0;
              if (col == COL_LAST) begin
                col      <= '0;
                row_cnt  <= row_cnt + A_ONE;
                row_base <= hdr_top_down ? row_base + H_STEP : row_base - H_STEP;
                pad_cnt  <= hdr_pad;
              end else begin
                col <= col + A_ONE;
              end
            end
          endcase
        end
        if (state == S_PAD && take) pad_cnt <= pad_cnt - 2'd1;
        if (state_nx == S_ERR && state != S_ERR)
          err_code <= load_fault ? ERR_TIMEOUT : hdr_err;
      end
    end
  end

endmodule

// File: doc/bmp_load_ctrl.md
Name: bmp_load_ctrl

Overview:
- Sequences the SD-card byte stream into the video framebuffer.
- Parses and validates the BMP header, skips to the pixel-data offset, and strips row padding.
- Converts bottom-up or top-down row order into linear framebuffer write addresses.
- Sits between sd_file_reader (outen/outbyte) and the framebuffer write port; drives status to the 7-segment display.

Parameters:
- H_ACTIVE, 640, required image width in pixels
- V_ACTIVE, 480, required image height in pixels (absolute value)
- ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
- TIMEOUT_CYCLES, 50_000_000, maximum idle clk cycles between stream bytes once loading has started

Ports:
- clk, in, 1, system clock
- rstn, in, 1, asynchronous active-low reset
- start, in, 1, pulse: arm a new load
- card_ok, in, 1, SD card initialised (card_stat==8)
- file_found, in, 1, from the SD reader
- outen, in, 1, byte strobe from the SD reader
- outbyte, in, 8, stream byte
- fb_we, out, 1, framebuffer write enable, single-cycle
- fb_addr, out, ADDR_WIDTH, write address (row*H_ACTIVE + col)
- fb_data, out, 24, {R,G,B}
- busy, out, 1, load in progress
- done, out, 1, full frame written; held
- error, out, 1, load aborted; held
- err_code, out, 3, 0 none, 1 bad signature, 2 bad size, 3 bpp!=24, 4 compressed, 5 offset<54, 6 timeout
- status, out, 4, 0 idle, 1 SD ok, 2 file/header, 3 loading, 4 display, E error

Behaviour:
- Reset (rstn=0, async): all outputs 0; status=0; state IDLE; all counters 0.
- States: IDLE, WAIT_FILE, HEADER, SKIP, PIXEL, PAD, DONE, ERR.
- IDLE: status=1 while card_ok, else 0.
  - start → WAIT_FILE, busy=1, done=0, error=0, err_code=0.
- start is ignored in WAIT_FILE through PAD. It is accepted in IDLE, DONE and ERR.
- A byte is consumed only on a cycle with outen=1 and file_found=1. byte_idx (32-bit) increments per consumed byte.
- WAIT_FILE: file_found=1 → HEADER, status=2.
- HEADER: capture bytes 0–53.
  - Signature: bytes 0,1 must be 0x42, 0x4D.
  - Little-endian fields: offset at bytes 10–13, width at 18–21, height at 22–25 (signed), bpp at 28–29, compression at 30–33.
- Validation happens on the cycle byte 53 is consumed, checked in priority order: signature, size (width==H_ACTIVE and |height|==V_ACTIVE), bpp==24, compression==0, offset>=54.
  - Any failure → ERR with that code.
  - Pass → SKIP, or directly to PIXEL if offset==54.
- Height sign sets row order:
  - height>0 (bottom-up): row_base starts at (V_ACTIVE-1)*H_ACTIVE and decrements by H_ACTIVE per row.
  - height<0 (top-down): row_base starts at 0 and increments by H_ACTIVE.
  - No multiplier is used; row_base is an adder/subtractor only.
- SKIP: discard bytes until byte_idx==offset, then enter PIXEL. status=3.
- PIXEL: byte phase 0=B, 1=G, 2=R.
  - On the R byte: fb_we=1 for one cycle, fb_data={R,G,B}, fb_addr=row_base+col.
  - Latency is 1 clk from the R byte strobe to fb_we; no other write path exists.
- End of row (col==H_ACTIVE-1 written):
  - col←0 and row_base is updated.
  - pad = width[1:0]. If pad≠0 → PAD; otherwise stay in PIXEL.
- PAD: discard pad bytes, then return to PIXEL.
- Last pixel (row count==V_ACTIVE-1, col==H_ACTIVE-1) written → DONE: done=1, busy=0, status=4. Trailing stream bytes are ignored.
- Timeout: in HEADER/SKIP/PIXEL/PAD, a counter counts cycles without a consumed byte; reaching TIMEOUT_CYCLES → ERR code 6. The counter is cleared on each consumed byte.
- file_found dropping in HEADER..PAD → ERR code 6, immediately.
- ERR: error=1, busy=0, status=E, fb_we=0. Held until start or reset.
- Restart from DONE/ERR clears done/error/err_code and all counters and returns to WAIT_FILE.
- Simultaneous start and byte strobe in DONE/ERR: the restart wins and the byte is not consumed.

Decomposition:
- Shared package bmp_pkg holds:
  - state encoding
  - err_code and status constants
  - BMP field offsets (10, 18, 22, 28, 30)
  - header length 54 and signature bytes
- One sub-module, bmp_hdr_parse: captures and validates the header, outputs offset, top_down, valid and err_code.
- The pixel/address sequencer stays in the top.

Test Plan:
- Valid 640x480 bottom-up stream, offset 54 → first fb_we at addr 306560 (479*640) with data {R,G,B} matching the first triple; last write at addr 639; done=1, status=4; exactly 307200 writes.
- Same image with height=-480 → first write addr 0, last addr 307199, done=1.
- Header with bytes 0,1 = 0x42,0x4E → error=1, err_code=1, status=E, zero fb_we.
- bpp=32 → err_code=3. Width=641 → err_code=2. offset=138 → bytes 54..137 dropped and first pixel taken from byte 138.
- With H_ACTIVE=3, V_ACTIVE=2, width 3: pad 3 bytes per row; insert 0xFF pad bytes → no writes from pad bytes, 6 writes total at addrs 3,4,5,0,1,2.
- outen stalls for TIMEOUT_CYCLES mid-pixel → err_code=6. rstn pulse mid-load → all outputs 0 asynchronously. Then start → busy=1, reload completes.
